uart_rx_frame: RTL and testbench

//  UART receive framer; sits directly downstream of the oversampling tick counter (its counting_done drives baud_tick).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_frame_sync_2ff.sv | 29 ++
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and line idle level.
// Also intended for use by the transmit block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_rx_frame_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter, so a serial line can come out of reset at its idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two register stages give the first stage time to settle from metastability.
  // NOTE: sequential state uses non-blocking assignments, so each stage loads the value the previous stage held before the clock edge.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer. Detects a start bit on a falling edge of the synchronised line.
// Samples each bit at mid-period using OVERSAMPLE baud ticks per bit.
// Delivers each word with a one-clock valid pulse plus parity and framing flags.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_FULL = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          HAS_PAR = (PARITY_EN != 0);
  localparam logic          ODD_PAR = (PARITY_ODD != 0);

  logic                 rx_s;
  logic                 rx_q;
  logic                 fall_edge;
  rx_state_t            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(.RESET_VAL(UART_IDLE_LVL)) u_sync (
    .clock  (clock),
    .nreset (nreset),
    .d      (rx),
    .q      (rx_s)
  );

  assign fall_edge = rx_q & ~rx_s;

  // State, counters, shift register and output registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rx_q         <= UART_IDLE_LVL;
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      rx_q         <= rx_s;
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  // Next-state logic: frame sequencing, mid-bit sampling and word delivery.
  always_comb begin
    // NOTE: every signal gets a default before the case, so paths that do not assign it cannot infer a latch.
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;

    unique case (state_q)
      IDLE: begin
        // An edge wins over a coincident tick; counting starts from zero.
        if (fall_edge) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          if (s_cnt_q == S_HALF) begin
            s_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = IDLE;  // line went back high before mid-bit: glitch
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (s_cnt_q == S_FULL) begin
            s_cnt_d = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};  // LSB arrives first
            if (bit_cnt_q == B_LAST) begin
              state_d = HAS_PAR ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          if (s_cnt_q == S_FULL) begin
            s_cnt_d   = '0;
            par_bad_d = ((^shreg_q) ^ rx_s) != ODD_PAR;
            state_d   = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (s_cnt_q == S_FULL) begin
            s_cnt_d      = '0;
            data_out_d   = shreg_q;
            perr_d       = HAS_PAR & par_bad_q;
            ferr_d       = ~rx_s;
            data_valid_d = 1'b1;
            // A start edge coinciding with the return to idle is not lost.
            state_d      = fall_edge ? START : IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance and an 8E1 instance.
// Expected words are queued when a frame is sent; monitors pop and compare on data_valid.
module tb_uart_rx_frame;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic       baud_tick;
  logic       rx, rx_p;
  logic [7:0] data_out, data_out_p;
  logic       dv, dv_p, perr, perr_p, ferr, ferr_p, busy, busy_p;

  exp_t exp_q[$];
  exp_t exp_pq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_div = 4;
  int   tick_cnt = 0;
  logic busy_seen;

  always #5 clk = ~clk;

  uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clock(clk), .nreset(nreset), .baud_tick(baud_tick), .rx(rx),
    .data_out(data_out), .data_valid(dv), .parity_error(perr),
    .framing_error(ferr), .busy(busy)
  );

  uart_rx_frame #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clock(clk), .nreset(nreset), .baud_tick(baud_tick), .rx(rx_p),
    .data_out(data_out_p), .data_valid(dv_p), .parity_error(perr_p),
    .framing_error(ferr_p), .busy(busy_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: even parity error when data ones plus parity bit is odd; framing error when stop is 0.
  function automatic exp_t model(input logic [7:0] d, input bit has_par, input bit pbit, input bit stop);
    exp_t e;
    e.data = d;
    e.perr = has_par && ((($countones(d) + int'(pbit)) % 2) != 0);
    e.ferr = !stop;
    return e;
  endfunction

  // Baud tick generator: one pulse every tick_div clocks, driven away from the active edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt++;
      baud_tick = (tick_cnt >= tick_div);
      if (baud_tick) tick_cnt = 0;
    end
  end

  task automatic drive_bit(input bit sel_p, input bit b);
    if (sel_p) rx_p = b; else rx = b;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel_p, input logic [7:0] d, input bit pbit, input bit stop);
    drive_bit(sel_p, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel_p, d[i]);
    if (sel_p) drive_bit(sel_p, pbit);
    drive_bit(sel_p, stop);
    if (!stop) drive_bit(sel_p, 1'b1);
  endtask

  task automatic push_send(input bit sel_p, input logic [7:0] d, input bit pbit, input bit stop);
    if (sel_p) exp_pq.push_back(model(d, 1'b1, pbit, stop));
    else       exp_q.push_back(model(d, 1'b0, pbit, stop));
    send_frame(sel_p, d, pbit, stop);
  endtask

  // Monitor for the 8N1 instance.
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (dv && dv_prev) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_width: data_valid high 2 clocks, expected 1 at %0t", $time);
    end
    if (dv) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: data 0x%0h, expected no pulse at %0t", data_out, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", 32'(data_out), 32'(e.data));
        check("parity_error", 32'(perr), 32'(e.perr));
        check("framing_error", 32'(ferr), 32'(e.ferr));
      end
    end
    dv_prev <= dv;
  end

  // Monitor for the parity instance.
  always @(negedge clk) begin
    if (dv_p) begin
      if (exp_pq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid_p: data 0x%0h, expected no pulse at %0t", data_out_p, $time);
      end else begin
        exp_t e;
        e = exp_pq.pop_front();
        check("data_p", 32'(data_out_p), 32'(e.data));
        check("parity_error_p", 32'(perr_p), 32'(e.perr));
        check("framing_error_p", 32'(ferr_p), 32'(e.ferr));
      end
    end
  end

  initial begin
    int w;
    logic [7:0] d;
    rx = 1'b1;
    rx_p = 1'b1;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_valid", 32'(dv), 0);
    check("rst_perr", 32'(perr), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_busy_p", 32'(busy_p), 0);
    nreset = 1'b1;
    repeat (8) @(negedge clk);

    // Basic 8N1 word.
    push_send(1'b0, 8'hA5, 1'b0, 1'b1);
    check("busy_after_a5", 32'(busy), 0);

    // Start glitch shorter than half a bit.
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4 * tick_div) @(negedge clk) if (busy) busy_seen = 1'b1;
    rx = 1'b1;
    repeat (60) @(negedge clk) if (busy) busy_seen = 1'b1;
    check("glitch_busy_seen", 32'(busy_seen), 1);
    check("glitch_busy_end", 32'(busy), 0);

    // Framing error, then cleared by a good frame.
    push_send(1'b0, 8'h3C, 1'b0, 1'b0);
    push_send(1'b0, 8'h01, 1'b0, 1'b1);

    // Even parity: wrong then right parity bit.
    push_send(1'b1, 8'h03, 1'b1, 1'b1);
    push_send(1'b1, 8'h03, 1'b0, 1'b1);

    // Reset in the middle of data bit 4 of 0xFF.
    rx = 1'b0;
    repeat (OS * tick_div) @(negedge clk);
    rx = 1'b1;
    repeat (OS * tick_div * 4 + OS * tick_div / 2) @(negedge clk);
    check("midframe_busy", 32'(busy), 1);
    nreset = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(dv), 0);
    check("midrst_ferr", 32'(ferr), 0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (2 * OS * tick_div) @(negedge clk);
    push_send(1'b0, 8'h55, 1'b0, 1'b1);

    // Back-to-back frames with a tick on every clock.
    tick_div = 1;
    push_send(1'b0, 8'h00, 1'b0, 1'b1);
    push_send(1'b0, 8'hFF, 1'b0, 1'b1);
    push_send(1'b0, 8'h81, 1'b0, 1'b1);

    // Break: one all-zero frame with framing error, then nothing until rx rises.
    tick_div = 2;
    exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
    rx = 1'b0;
    repeat (12 * OS * tick_div) @(negedge clk);
    rx = 1'b1;
    repeat (2 * OS * tick_div) @(negedge clk);
    check("break_busy_end", 32'(busy), 0);

    // Randomised frames on both instances.
    for (int i = 0; i < 20; i++) begin
      tick_div = $urandom_range(1, 4);
      d = 8'($urandom);
      push_send(1'b0, d, 1'b0, $urandom_range(0, 7) != 0);
    end
    for (int i = 0; i < 12; i++) begin
      tick_div = $urandom_range(1, 4);
      d = 8'($urandom);
      push_send(1'b1, d, 1'($urandom), $urandom_range(0, 7) != 0);
    end

    w = 0;
    while ((exp_q.size() + exp_pq.size()) != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", 32'(exp_q.size() + exp_pq.size()), 0);
    check("final_busy", 32'(busy | busy_p), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
